rf_wport_arb: RTL and testbench
===============================

# rf_wport_arb

Register-file write-port arbiter shared between the in-order pipeline retire path (WB output) and the long-latency unit (divider/multiplier result return). It grants the single RF write port to one source per cycle: pipeline by priority, long-latency results buffered in a small FIFO. The selected write is registered onto the RF write port and the trace-debug outputs.

## Interface
- LU_FIFO_DEPTH, 2, long-latency result FIFO entries; power of two, ≥2
- STARVE_LIMIT, 4, consecutive denied cycles before the LU head is forced through (only with RF_WPORT_FAIR_EN)
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- pipe_valid  in  1  pipeline retire request
- pipe_ready  out  1  pipeline request accepted this cycle
- pipe_we  in  1  pipeline instruction writes the RF
- pipe_dest  in  5  pipeline destination register
- pipe_data  in  32  pipeline write data
- pipe_pc  in  32  pipeline instruction PC
- lu_valid  in  1  LU result available
- lu_ready  out  1  FIFO can accept the LU result
- lu_dest  in  5  LU destination register
- lu_data  in  32  LU result
- lu_pc  in  32  LU instruction PC
- rf_we  out  1  RF write enable (registered)
- rf_waddr  out  5  RF write address (registered)
- rf_wdata  out  32  RF write data (registered)
- wb_pc  out  32  PC of the retired/written instruction (registered)
- wb_src  out  1  source of the current output: 0 pipeline, 1 LU (registered)
- lu_pending  out  1  FIFO non-empty

## Operation
- FIFO: push when lu_valid && lu_ready; lu_ready = (count != LU_FIFO_DEPTH); no bypass of an empty FIFO; pointers wrap modulo LU_FIFO_DEPTH; count width clog2(LU_FIFO_DEPTH)+1.
- Grant per cycle, exactly one or none:
  - force_lu (fair mode only): lu_pending && starve_cnt == STARVE_LIMIT → grant LU, pipe_ready = 0.
  - else pipe_valid → grant pipeline, pipe_ready = 1.
  - else lu_pending → grant LU (pop head).
  - else idle.
- pipe_ready = !force_lu (independent of pipe_valid); 1 in strict mode.
- Pipeline grant consumes the slot even when pipe_we = 0: rf_we = 0, wb_pc = pipe_pc, wb_src = 0.
- LU grant: rf_we = 1, rf_waddr/rf_wdata/wb_pc = FIFO head, wb_src = 1.
- Idle cycle: rf_we = 0; rf_waddr, rf_wdata, wb_pc, wb_src hold their previous values.
- Push and pop in the same cycle: count unchanged; allowed only when not full (lu_ready is evaluated before the pop).
- Ordering between sources is grant order; WAW between sources is prevented upstream by the scoreboard and is not checked here.

## Timing
- Reset (asynchronous assert): rf_we 0, rf_waddr 0, rf_wdata 0, wb_pc 0, wb_src 0, FIFO empty, starve_cnt 0, lu_pending 0, lu_ready 1, pipe_ready 1.
- Pipeline latency: accepted at edge N → RF write visible during cycle N+1.
- LU latency: pushed at edge N → earliest output at N+2 (FIFO, then output register).
- Reset mid-operation discards FIFO contents and any pending output write; no write issues on the release cycle.
- lu_ready and pipe_ready are combinational from registered state only; no combinational path from the valid inputs.

## Configuration
- RF_WPORT_FAIR_EN defined: starve_cnt (width clog2(STARVE_LIMIT+1)) increments each cycle lu_pending && pipeline granted, saturates at STARVE_LIMIT, clears on any LU grant or when the FIFO is empty; at the limit force_lu applies for one cycle.
- Undefined: strict pipeline priority, no counter, pipe_ready tied to 1; the LU drains only in pipeline-idle cycles.

## Structure
- Shared macro header: DEST_LEN (5), DATA_LEN (32), PC_LEN (32), LU entry width/packing {pc, dest, data}, wb_src encodings.
- Sub-module rf_wport_fifo: parameterized synchronous FIFO (push/pop/full/empty/head), reused by the arbiter only.

## Test plan
- Pipeline only: pipe_valid, we=1, dest=5, data=0x1234, pc=0x1c000000 → next cycle rf_we=1, waddr=5, wdata=0x1234, wb_pc=0x1c000000, wb_src=0.
- LU only, FIFO empty: push dest=7, data=0xDEAD → rf_we=1, waddr=7 exactly two edges later; lu_pending 1 for one cycle.
- Fill: three back-to-back LU pushes while pipe_valid is held high → lu_ready=0 after two pushes (depth 2); third accepted only after a pop.
- Fairness (FAIR_EN, STARVE_LIMIT=4): FIFO holds one entry, pipe_valid held high → pipe_ready=0 in the 5th cycle, LU written, then pipeline resumes; strict build: LU never written while pipe_valid=1.
- Non-writing retire: pipe_valid, we=0, pc=0x1c000010 → rf_we=0, wb_pc=0x1c000010; a buffered LU entry waits.
- Async reset while FIFO is full and an output write is pending → all outputs at reset values immediately, lu_ready=1; no write after release.

Source files
------------

// File: rtl/rf_wport_arb_pkg.sv
// Shared widths, LU FIFO entry layout and write-source encodings for the RF write-port arbiter.
package rf_wport_arb_pkg;

  localparam int unsigned DEST_LEN = 5;
  localparam int unsigned DATA_LEN = 32;
  localparam int unsigned PC_LEN   = 32;

  typedef struct packed {
    logic [PC_LEN-1:0]   pc;
    logic [DEST_LEN-1:0] dest;
    logic [DATA_LEN-1:0] data;
  } lu_entry_t;

  localparam int unsigned LU_ENTRY_W = $bits(lu_entry_t);

  typedef enum logic {
    WB_SRC_PIPE = 1'b0,
    WB_SRC_LU   = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rf_wport_fifo.sv
// Small synchronous FIFO for long-latency results; DEPTH must be a power of two so pointers wrap naturally.
module rf_wport_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: pipeline retire has priority, LU results are buffered in a FIFO.
// Optional starvation guard for the LU head is enabled by defining RF_WPORT_FAIR_EN.
module rf_wport_arb
  import rf_wport_arb_pkg::*;
#(
  parameter int unsigned LU_FIFO_DEPTH = 2,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                pipe_valid,
  output logic                pipe_ready,
  input  logic                pipe_we,
  input  logic [DEST_LEN-1:0] pipe_dest,
  input  logic [DATA_LEN-1:0] pipe_data,
  input  logic [PC_LEN-1:0]   pipe_pc,
  input  logic                lu_valid,
  output logic                lu_ready,
  input  logic [DEST_LEN-1:0] lu_dest,
  input  logic [DATA_LEN-1:0] lu_data,
  input  logic [PC_LEN-1:0]   lu_pc,
  output logic                rf_we,
  output logic [DEST_LEN-1:0] rf_waddr,
  output logic [DATA_LEN-1:0] rf_wdata,
  output logic [PC_LEN-1:0]   wb_pc,
  output logic                wb_src,
  output logic                lu_pending
);

  if (LU_FIFO_DEPTH < 2 || (LU_FIFO_DEPTH & (LU_FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_err
    $error("rf_wport_arb: LU_FIFO_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
  end

  lu_entry_t               lu_in;
  lu_entry_t               lu_head;
  logic [LU_ENTRY_W-1:0]   head_bits;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    lu_push;
  logic                    force_lu;
  logic                    grant_pipe;
  logic                    grant_lu;
  wb_src_e                 wb_src_q;

  assign lu_in      = '{pc: lu_pc, dest: lu_dest, data: lu_data};
  assign lu_head    = lu_entry_t'(head_bits);
  assign lu_ready   = !fifo_full;
  assign lu_pending = !fifo_empty;
  assign lu_push    = lu_valid && !fifo_full;

  rf_wport_fifo #(
    .DEPTH (LU_FIFO_DEPTH),
    .WIDTH (LU_ENTRY_W)
  ) u_lu_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (lu_push),
    .pop    (grant_lu),
    .wdata  (lu_in),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (head_bits)
  );

`ifdef RF_WPORT_FAIR_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt;

  assign force_lu = lu_pending && (starve_cnt == STARVE_W'(STARVE_LIMIT));

  // Counts pipeline wins while an LU result waits; saturates at the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (fifo_empty || grant_lu) begin
      starve_cnt <= '0;
    end else if (grant_pipe && (starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end
`else
  assign force_lu = 1'b0;
`endif

  assign pipe_ready = !force_lu;
  assign grant_pipe = pipe_valid && !force_lu;
  assign grant_lu   = force_lu || (!pipe_valid && lu_pending);

  // Output register; idle cycles drop the write enable and hold the rest.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_pc    <= '0;
      wb_src_q <= WB_SRC_PIPE;
    end else begin
      rf_we <= 1'b0;
      if (grant_pipe) begin
        rf_we    <= pipe_we;
        rf_waddr <= pipe_dest;
        rf_wdata <= pipe_data;
        wb_pc    <= pipe_pc;
        wb_src_q <= WB_SRC_PIPE;
      end else if (grant_lu) begin
        rf_we    <= 1'b1;
        rf_waddr <= lu_head.dest;
        rf_wdata <= lu_head.data;
        wb_pc    <= lu_head.pc;
        wb_src_q <= WB_SRC_LU;
      end
    end
  end

  assign wb_src = wb_src_q;

endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed bench for rf_wport_arb: vector table plus fill, fairness and async-reset sequences.
// Expectations follow RF_WPORT_FAIR_EN when it is defined for the build.
module tb_rf_wport_arb;

`ifdef RF_WPORT_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        pipe_valid, pipe_ready, pipe_we;
  logic [4:0]  pipe_dest;
  logic [31:0] pipe_data, pipe_pc;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_dest;
  logic [31:0] lu_data, lu_pc;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, wb_pc;
  logic        wb_src, lu_pending;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_wport_arb #(.LU_FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pipe_valid (pipe_valid),
    .pipe_ready (pipe_ready),
    .pipe_we    (pipe_we),
    .pipe_dest  (pipe_dest),
    .pipe_data  (pipe_data),
    .pipe_pc    (pipe_pc),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_dest    (lu_dest),
    .lu_data    (lu_data),
    .lu_pc      (lu_pc),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .wb_pc      (wb_pc),
    .wb_src     (wb_src),
    .lu_pending (lu_pending)
  );

  typedef struct {
    logic        pv;
    logic        pwe;
    logic [4:0]  pd;
    logic [31:0] pdata;
    logic [31:0] ppc;
    logic        lv;
    logic [4:0]  ld;
    logic [31:0] ldata;
    logic [31:0] lpc;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [31:0] e_pc;
    logic        e_src;
    logic        e_pend;
    logic        e_lrdy;
    logic        chk_wa;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic e_we, input logic [4:0] e_wa,
                           input logic [31:0] e_wd, input logic [31:0] e_pc, input logic e_src,
                           input logic e_pend, input logic e_lrdy, input logic chk_wa);
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(e_we));
    if (chk_wa) begin
      chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(e_wa));
      chk({tag, ".rf_wdata"}, rf_wdata, e_wd);
    end
    chk({tag, ".wb_pc"}, wb_pc, e_pc);
    chk({tag, ".wb_src"}, 32'(wb_src), 32'(e_src));
    chk({tag, ".lu_pending"}, 32'(lu_pending), 32'(e_pend));
    chk({tag, ".lu_ready"}, 32'(lu_ready), 32'(e_lrdy));
  endtask

  task automatic set_pipe(input logic v, input logic we, input logic [4:0] d,
                          input logic [31:0] data, input logic [31:0] pc);
    pipe_valid = v; pipe_we = we; pipe_dest = d; pipe_data = data; pipe_pc = pc;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] d, input logic [31:0] data,
                        input logic [31:0] pc);
    lu_valid = v; lu_dest = d; lu_data = data; lu_pc = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          pv pwe pd  pdata        ppc           lv ld  ldata        lpc           we wa  wd           pc            src pend lrdy chk
    vecs[0]  = '{1, 1, 5,  32'h1234,    32'h1c000000, 0, 0,  32'h0,       32'h0,        1, 5,  32'h1234,    32'h1c000000, 0,  0,   1,   1};
    vecs[1]  = '{0, 0, 0,  32'h0,       32'h0,        0, 0,  32'h0,       32'h0,        0, 5,  32'h1234,    32'h1c000000, 0,  0,   1,   1};
    vecs[2]  = '{0, 0, 0,  32'h0,       32'h0,        1, 7,  32'hDEAD,    32'h1c000100, 0, 5,  32'h1234,    32'h1c000000, 0,  1,   1,   1};
    vecs[3]  = '{0, 0, 0,  32'h0,       32'h0,        0, 0,  32'h0,       32'h0,        1, 7,  32'hDEAD,    32'h1c000100, 1,  0,   1,   1};
    vecs[4]  = '{0, 0, 0,  32'h0,       32'h0,        0, 0,  32'h0,       32'h0,        0, 7,  32'hDEAD,    32'h1c000100, 1,  0,   1,   1};
    vecs[5]  = '{1, 0, 3,  32'h55,      32'h1c000010, 1, 9,  32'hBEEF,    32'h1c000200, 0, 0,  32'h0,       32'h1c000010, 0,  1,   1,   0};
    vecs[6]  = '{1, 1, 10, 32'hA0A0,    32'h1c000014, 0, 0,  32'h0,       32'h0,        1, 10, 32'hA0A0,    32'h1c000014, 0,  1,   1,   1};
    vecs[7]  = '{0, 0, 0,  32'h0,       32'h0,        0, 0,  32'h0,       32'h0,        1, 9,  32'hBEEF,    32'h1c000200, 1,  0,   1,   1};
    vecs[8]  = '{1, 1, 2,  32'h22,      32'h400,      1, 1,  32'h11,      32'h300,      1, 2,  32'h22,      32'h400,      0,  1,   1,   1};
    vecs[9]  = '{0, 0, 0,  32'h0,       32'h0,        1, 3,  32'h33,      32'h500,      1, 1,  32'h11,      32'h300,      1,  1,   1,   1};
    vecs[10] = '{0, 0, 0,  32'h0,       32'h0,        0, 0,  32'h0,       32'h0,        1, 3,  32'h33,      32'h500,      1,  0,   1,   1};
    vecs[11] = '{0, 0, 0,  32'h0,       32'h0,        0, 0,  32'h0,       32'h0,        0, 3,  32'h33,      32'h500,      1,  0,   1,   1};

    resetn = 1'b0;
    set_pipe(0, 0, 0, 0, 0);
    set_lu(0, 0, 0, 0);
    #12;
    check_out("reset", 0, 0, 0, 0, 0, 0, 1, 1);
    chk("reset.pipe_ready", 32'(pipe_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    #4;

    // Table-driven single-cycle behaviour
    for (int i = 0; i < 12; i++) begin
      set_pipe(vecs[i].pv, vecs[i].pwe, vecs[i].pd, vecs[i].pdata, vecs[i].ppc);
      set_lu(vecs[i].lv, vecs[i].ld, vecs[i].ldata, vecs[i].lpc);
      #1;
      chk($sformatf("vec%0d.pipe_ready", i), 32'(pipe_ready), 32'd1);
      chk($sformatf("vec%0d.lu_ready_pre", i), 32'(lu_ready), 32'd1);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_wa, vecs[i].e_wd, vecs[i].e_pc,
                vecs[i].e_src, vecs[i].e_pend, vecs[i].e_lrdy, vecs[i].chk_wa);
    end

    // Fill the FIFO while the pipeline holds the port, then drain in order
    set_pipe(1, 1, 4, 32'h100, 32'h1000);
    set_lu(1, 11, 32'hE1, 32'h2E1);
    step();
    check_out("fill.push1", 1, 4, 32'h100, 32'h1000, 0, 1, 1, 1);
    set_lu(1, 12, 32'hE2, 32'h2E2);
    step();
    check_out("fill.push2", 1, 4, 32'h100, 32'h1000, 0, 1, 0, 1);
    set_lu(1, 13, 32'hE3, 32'h2E3);
    step();
    check_out("fill.push3_blocked", 1, 4, 32'h100, 32'h1000, 0, 1, 0, 1);
    step();
    check_out("fill.hold", 1, 4, 32'h100, 32'h1000, 0, 1, 0, 1);
    set_pipe(0, 0, 0, 0, 0);
    step();
    check_out("fill.pop1", 1, 11, 32'hE1, 32'h2E1, 1, 1, 1, 1);
    step();
    check_out("fill.pop2_push3", 1, 12, 32'hE2, 32'h2E2, 1, 1, 1, 1);
    set_lu(0, 0, 0, 0);
    step();
    check_out("fill.pop3", 1, 13, 32'hE3, 32'h2E3, 1, 0, 1, 1);
    step();
    check_out("fill.idle", 0, 13, 32'hE3, 32'h2E3, 1, 0, 1, 1);

    // One buffered LU entry against a continuously valid pipeline
    set_pipe(1, 1, 6, 32'h60, 32'h1c000800);
    set_lu(1, 8, 32'h88, 32'h1c000900);
    step();
    check_out("fair.k0", 1, 6, 32'h60, 32'h1c000800, 0, 1, 1, 1);
    set_lu(0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      logic forced;
      logic pend_exp;
      forced   = FAIR && (k == 5);
      pend_exp = FAIR ? (k < 5) : 1'b1;
      set_pipe(1, 1, 6, 32'h60 + 32'(k), 32'h1c000800 + 32'(4 * k));
      #1;
      chk($sformatf("fair.k%0d.pipe_ready", k), 32'(pipe_ready), 32'(!forced));
      step();
      if (forced)
        check_out($sformatf("fair.k%0d", k), 1, 8, 32'h88, 32'h1c000900, 1, 0, 1, 1);
      else
        check_out($sformatf("fair.k%0d", k), 1, 6, 32'h60 + 32'(k), 32'h1c000800 + 32'(4 * k),
                  0, pend_exp, 1, 1);
    end
    set_pipe(0, 0, 0, 0, 0);
    step();
    if (FAIR)
      check_out("fair.after", 0, 6, 32'h68, 32'h1c000820, 0, 0, 1, 1);
    else
      check_out("fair.after", 1, 8, 32'h88, 32'h1c000900, 1, 0, 1, 1);
    step();

    // Async reset with a full FIFO and a registered write in flight
    set_pipe(1, 1, 20, 32'hCAFE, 32'h700);
    set_lu(1, 21, 32'hA1, 32'h7A1);
    step();
    set_lu(1, 22, 32'hA2, 32'h7A2);
    step();
    check_out("rst.prefill", 1, 20, 32'hCAFE, 32'h700, 0, 1, 0, 1);
    #2;
    resetn = 1'b0;
    #1;
    check_out("rst.async", 0, 0, 0, 0, 0, 0, 1, 1);
    chk("rst.async.pipe_ready", 32'(pipe_ready), 32'd1);
    set_pipe(0, 0, 0, 0, 0);
    set_lu(0, 0, 0, 0);
    step();
    step();
    @(negedge clk);
    resetn = 1'b1;
    step();
    check_out("rst.release1", 0, 0, 0, 0, 0, 0, 1, 1);
    step();
    check_out("rst.release2", 0, 0, 0, 0, 0, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
